reg_bank_pp: RTL and testbench
==============================

Name: reg_bank_pp

Overview:
Parametrised bank of DEPTH parallel-in/parallel-out registers, each WIDTH bits wide. It is the generalised successor of the single 4-bit enable/set/reset register.
- One synchronous write port and two registered read ports.
- Global synchronous set, plus a sequential clear sweep that zeroes one register per cycle with a busy flag.
- Used as the general-purpose register storage in Guia5 datapath exercises.

Parameters:
WIDTH, 4, bits per register (>=1)
DEPTH, 4, number of registers (>=2, need not be a power of 2)
AW, $clog2(DEPTH), address width (derived, do not override)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; zeroes every register and every output
set  input  1  synchronous; loads all-ones into every register
enable  input  1  write enable for the write port
wa  input  AW  write address
D  input  WIDTH  write data
ra0  input  AW  read address, port 0
ra1  input  AW  read address, port 1
Q0  output  WIDTH  registered read data, port 0
Q1  output  WIDTH  registered read data, port 1
clr_start  input  1  pulse to start the clear sweep
busy  output  1  high while the clear sweep runs
done  output  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (reset=1 at an edge):
  - All registers, Q0, Q1, busy and done go to 0; FSM goes to IDLE.
  - Reset wins over every other input, including mid-sweep.
- Priority per edge: reset > set > sweep clear > write.
- set=1:
  - Every register becomes all-ones. A write in the same cycle is discarded.
  - If the sweep is active, it is aborted: FSM to IDLE, busy=0, no done pulse.
- Write: enable=1 and wa<DEPTH -> reg[wa] <= D. wa>=DEPTH -> write ignored.
- Read:
  - Q0 <= reg[ra0] and Q1 <= reg[ra1] every cycle, giving 1-cycle latency.
  - Address >=DEPTH -> output 0.
  - Both ports may address the same register.
- Read-during-write, without bypass: Q shows the pre-write contents.
- Clear-sweep FSM:
  - IDLE: busy=0. clr_start=1 (and set=0) -> SWEEP, ptr=0.
  - SWEEP: busy=1; reg[ptr] <= 0; ptr increments each cycle.
    - When ptr==DEPTH-1, that register is cleared -> DONE.
    - clr_start is ignored while in SWEEP.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
  - Sweep length is DEPTH cycles of busy, then the done pulse.
- Write during sweep:
  - Allowed only to registers not yet swept (wa>ptr), and it takes effect.
  - wa<=ptr -> write is discarded; the sweep result is authoritative.
- Reads during the sweep are legal and return the current contents.

Optional Feature:
REG_BANK_BYPASS_EN.
- Defined: write-to-read forwarding is enabled. If enable=1, wa<DEPTH, wa==raN and no higher-priority event (reset/set/sweep of that entry) occurs, then QN <= D in that same edge.
- Undefined: no forwarding; QN shows the old value and the new value is visible one cycle later.

Test Plan:
- reset=1 for 1 cycle, then idle -> Q0=Q1=0, busy=0, done=0; all registers read back 0.
- WIDTH=4, DEPTH=4: enable=1, write wa=2 D=1101, then wa=1 D=0010 -> ra0=2 gives Q0=1101 and ra1=1 gives Q1=0010 one cycle after the address is applied.
- enable=0, wa=2, D=1111 -> Q0 at ra0=2 stays 1101. Then set=1 with enable=1 -> all four registers read 1111 and the write is discarded.
- Read/write same cycle: wa=ra0=3, D=0101.
  - Bypass off -> Q0 shows old value, then 0101 one cycle later.
  - REG_BANK_BYPASS_EN -> Q0=0101 after that edge.
- After set, pulse clr_start -> busy high for exactly 4 cycles, done pulses once, all registers 0000.
  - Write wa=3 D=1010 during the sweep's 2nd cycle -> reg3 still ends at 0000.
- Start the sweep, assert reset on the 2nd busy cycle -> busy=0 the next cycle, no done pulse, all registers 0.
- Repeat the sweep with DEPTH=5 -> busy for 5 cycles; write and read at address 7 are ignored and return 0.

Source files
------------

// File: rtl/reg_bank_pp.sv
// reg_bank_pp
//   Bank of DEPTH parallel-in/parallel-out registers, each WIDTH bits wide.
//   One synchronous write port, two registered read ports (1-cycle latency),
//   a global synchronous set, and a clear sweep that zeroes one register per
//   cycle while busy is high. A one-cycle done pulse marks the end of the sweep.
//
//   Priority per edge: reset > set > sweep clear > write.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset (registers, Q0/Q1, FSM)
//   set        synchronous load of all-ones into every register
//   enable     write enable
//   wa, D      write address / data (wa >= DEPTH ignored)
//   ra0, ra1   read addresses (>= DEPTH reads as 0)
//   Q0, Q1     registered read data
//   clr_start  starts the clear sweep from IDLE
//   busy       high while the sweep runs (DEPTH cycles)
//   done       one-cycle pulse after the last register is cleared
//
// Build option
//   REG_BANK_BYPASS_EN : when defined, an accepted write to the address being
//   read is forwarded to Q0/Q1 on the same edge. Otherwise a read in the
//   same cycle as a write returns the pre-write contents.

module reg_bank_pp #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             enable,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] D,
   input  logic [AW-1:0]    ra0,
   input  logic [AW-1:0]    ra1,
   output logic [WIDTH-1:0] Q0,
   output logic [WIDTH-1:0] Q1,
   input  logic             clr_start,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // One extra bit so DEPTH itself is representable for range checks.
   localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [1:0]       state;
   logic [AW-1:0]    ptr;

   logic             wa_ok, ra0_ok, ra1_ok, wr_en;
   logic [WIDTH-1:0] rd0, rd1;

   assign wa_ok  = {1'b0, wa}  < DEPTH_X;
   assign ra0_ok = {1'b0, ra0} < DEPTH_X;
   assign ra1_ok = {1'b0, ra1} < DEPTH_X;

   // During the sweep, entries at or behind the pointer belong to the sweep;
   // only not-yet-swept entries may still be written.
   assign wr_en = enable && wa_ok && !set &&
                  !(state == S_SWEEP && wa <= ptr);

   always_comb begin
      rd0 = ra0_ok ? mem[ra0] : '0;
      rd1 = ra1_ok ? mem[ra1] : '0;
`ifdef REG_BANK_BYPASS_EN
      if (wr_en && wa == ra0) rd0 = D;
      if (wr_en && wa == ra1) rd1 = D;
`endif
   end

   assign busy = (state == S_SWEEP);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         Q0    <= '0;
         Q1    <= '0;
         state <= S_IDLE;
         ptr   <= '0;
      end else begin
         Q0 <= rd0;
         Q1 <= rd1;
         if (set) begin
            // Set also aborts a running sweep without a done pulse.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
            state <= S_IDLE;
            ptr   <= '0;
         end else begin
            if (wr_en) mem[wa] <= D;
            case (state)
               S_IDLE: begin
                  if (clr_start) begin
                     state <= S_SWEEP;
                     ptr   <= '0;
                  end
               end
               S_SWEEP: begin
                  mem[ptr] <= '0;
                  if (ptr == LAST) begin
                     state <= S_DONE;
                     ptr   <= '0;
                  end else begin
                     ptr <= ptr + AW'(1);
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_pp.sv
module tb_reg_bank_pp;

   localparam int WIDTH = 4;
   localparam int DEPTH = 5;
   localparam int AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             reset, set, enable, clr_start;
   logic [AW-1:0]    wa, ra0, ra1;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q0, Q1;
   logic             busy, done;

   reg_bank_pp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .set(set), .enable(enable),
      .wa(wa), .D(D), .ra0(ra0), .ra1(ra1), .Q0(Q0), .Q1(Q1),
      .clr_start(clr_start), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] q0;
      logic [WIDTH-1:0] q1;
      logic             busy;
      logic             done;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;

   // Reference model: plain array of register values plus sweep position
   // (-1 when no sweep is running) and a pending done flag.
   logic [WIDTH-1:0] model [DEPTH];
   int               sweep_pos = -1;
   bit               done_now  = 1'b0;

   task automatic drive(input logic r, input logic s, input logic en,
                        input int w_a, input int d, input int r0, input int r1,
                        input logic cs);
      exp_t e;
      bit   wr_ok;
      reset = r; set = s; enable = en; clr_start = cs;
      wa = AW'(w_a); D = WIDTH'(d); ra0 = AW'(r0); ra1 = AW'(r1);
      if (r) begin
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
         sweep_pos = -1; done_now = 1'b0;
         e = '0;
      end else begin
         e.q0 = (r0 < DEPTH) ? model[r0] : '0;
         e.q1 = (r1 < DEPTH) ? model[r1] : '0;
         wr_ok = en && (w_a < DEPTH) && !s && !(sweep_pos >= 0 && w_a <= sweep_pos);
`ifdef REG_BANK_BYPASS_EN
         if (wr_ok && w_a == r0) e.q0 = WIDTH'(d);
         if (wr_ok && w_a == r1) e.q1 = WIDTH'(d);
`endif
         if (s) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '1;
            sweep_pos = -1; done_now = 1'b0;
         end else begin
            if (wr_ok) model[w_a] = WIDTH'(d);
            if (sweep_pos >= 0) begin
               model[sweep_pos] = '0;
               if (sweep_pos == DEPTH-1) begin
                  sweep_pos = -1; done_now = 1'b1;
               end else begin
                  sweep_pos++;
               end
            end else if (done_now) begin
               done_now = 1'b0;
            end else if (cs) begin
               sweep_pos = 0;
            end
         end
         e.busy = (sweep_pos >= 0);
         e.done = done_now;
      end
      sb.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic s, input logic en,
                      input int w_a, input int d, input int r0, input int r1,
                      input logic cs);
      @(negedge clk);
      drive(r, s, en, w_a, d, r0, r1, cs);
   endtask

   task automatic idle_read(input int r0, input int r1);
      cyc(0, 0, 0, 0, 0, r0, r1, 0);
   endtask

   // Monitor: outputs are presented every cycle; compare each against the
   // oldest queued expectation.
   always @(posedge clk) begin
      #1;
      cycle++;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         tests++;
         if ({Q0, Q1, busy, done} !== e) begin
            fails++;
            $display("FAIL outputs cyc=%0d got Q0=%b Q1=%b busy=%b done=%b expected Q0=%b Q1=%b busy=%b done=%b",
                     cycle, Q0, Q1, busy, done, e.q0, e.q1, e.busy, e.done);
         end
      end
   end

   // Starts a sweep and counts busy cycles / done pulses. Optionally writes
   // wa=3 or asserts reset on the 2nd busy cycle.
   task automatic run_sweep(input bit wr2, input bit rst2, input int exp_nb, input int exp_nd);
      int  nb = 0, nd = 0;
      bit  fired = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3*DEPTH; k++) begin
         @(negedge clk);
         if (busy) nb++;
         if (done) nd++;
         if (nb == 2 && !fired && rst2) begin
            fired = 1'b1; drive(1, 0, 0, 0, 0, 0, 0, 0);
         end else if (nb == 2 && !fired && wr2) begin
            fired = 1'b1; drive(0, 0, 1, 3, 4'b1010, 3, 0, 0);
         end else begin
            drive(0, 0, 0, 0, 0, k % DEPTH, (k+1) % DEPTH, 0);
         end
      end
      tests++;
      if (nb != exp_nb || nd != exp_nd) begin
         fails++;
         $display("FAIL sweep_len got busy=%0d done=%0d expected busy=%0d done=%0d",
                  nb, nd, exp_nb, exp_nd);
      end
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) idle_read(i, DEPTH-1-i);
   endtask

   initial begin
      reset = 1; set = 0; enable = 0; clr_start = 0;
      wa = '0; D = '0; ra0 = '0; ra1 = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      read_all();

      // basic writes and reads
      cyc(0, 0, 1, 2, 4'b1101, 0, 0, 0);
      cyc(0, 0, 1, 1, 4'b0010, 0, 0, 0);
      idle_read(2, 1);
      idle_read(2, 1);
      cyc(0, 0, 0, 2, 4'b1111, 2, 1, 0);
      idle_read(2, 2);
      // set beats a same-cycle write
      cyc(0, 1, 1, 0, 4'b0101, 0, 0, 0);
      read_all();
      // read and write of the same register in one cycle
      cyc(0, 0, 1, 3, 4'b0101, 3, 3, 0);
      idle_read(3, 3);

      // full sweep from all-ones, write to reg3 on 2nd busy cycle
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      run_sweep(1, 0, DEPTH, 1);
      read_all();

      // sweep interrupted by reset
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      run_sweep(0, 1, 2, 0);
      read_all();

      // out-of-range address: write ignored, read returns 0
      cyc(0, 0, 1, 7, 4'b1111, 7, 7, 0);
      idle_read(7, 6);
      read_all();

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
             $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
             ($urandom_range(0, 7) == 0));
      end
      read_all();

      @(posedge clk);
      #2;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
